lc4_regfile_wb: RTL and testbench



---
 rtl/lc4_regfile_wb_pkg.sv | 17 +
 rtl/lc4_regfile_wb_if.sv | 40 ++++
 rtl/lc4_nzp_gen.sv | 22 ++
 rtl/lc4_regfile_wb.sv | 81 ++++++++
 tb/tb_lc4_regfile_wb.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lc4_regfile_wb_pkg.sv
// Shared constants and types for the LC4 writeback register file.
// Build option: LC4_RF_BYPASS_EN enables write-through read bypass.
package lc4_regfile_wb_pkg;

  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_N     = 3'b100;
  localparam nzp_t NZP_Z     = 3'b010;
  localparam nzp_t NZP_P     = 3'b001;
  localparam nzp_t NZP_RESET = 3'b000;

  localparam logic PRIV_RESET = 1'b1;

  localparam int N_REGS_DEF = 8;
  localparam int DW_DEF     = 16;

endpackage

// File: rtl/lc4_regfile_wb_if.sv
// Read/write/commit bundle between the datapath and the LC4 writeback state.
// Datapath side is master; the register file is slave.
interface lc4_regfile_wb_if
  import lc4_regfile_wb_pkg::*;
#(
  parameter int AW = 3,
  parameter int DW = 16
);

  logic          gwe;
  logic [AW-1:0] i_rs;
  logic [AW-1:0] i_rt;
  logic [DW-1:0] o_rs_data;
  logic [DW-1:0] o_rt_data;
  logic [AW-1:0] i_rd;
  logic [DW-1:0] i_wdata;
  logic          i_rd_we;
  logic          i_nzp_we;
  logic          i_is_trap;
  logic          i_is_rti;
  nzp_t          o_nzp;
  logic          o_priv;

  modport master (
    output gwe, i_rs, i_rt, i_rd, i_wdata,
    output i_rd_we, i_nzp_we,
    output i_is_trap, i_is_rti,
    input  o_rs_data, o_rt_data,
    input  o_nzp, o_priv
  );

  modport slave (
    input  gwe, i_rs, i_rt, i_rd, i_wdata,
    input  i_rd_we, i_nzp_we,
    input  i_is_trap, i_is_rti,
    output o_rs_data, o_rt_data,
    output o_nzp, o_priv
  );

endinterface

// File: rtl/lc4_nzp_gen.sv
// Maps a data word to its one-hot LC4 condition code {N,Z,P}.
// Shared with the branch-prediction check logic.
module lc4_nzp_gen
  import lc4_regfile_wb_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] data,
  output nzp_t          nzp
);

  // Sign bit wins, then zero, else positive
  always_comb begin
    nzp = NZP_P;
    unique case (1'b1)
      data[DW-1]:     nzp = NZP_N;
      (data == '0):   nzp = NZP_Z;
      default:        nzp = NZP_P;
    endcase
  end

endmodule

// File: rtl/lc4_regfile_wb.sv
// LC4 writeback state: GPR array, NZP condition code and PSR priv bit.
// Build option: LC4_RF_BYPASS_EN adds same-cycle write-through on reads.
module lc4_regfile_wb
  import lc4_regfile_wb_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF,
  parameter int DW     = DW_DEF
) (
  input logic           clk,
  input logic           rst,
  lc4_regfile_wb_if.slave rf
);

  localparam int AW = $clog2(N_REGS);

  logic [DW-1:0] regs [N_REGS];
  nzp_t          nzp_q;
  logic          priv_q;
  nzp_t          nzp_next;
  logic          rd_wr;

  assign rd_wr = rf.gwe & rf.i_rd_we;

  lc4_nzp_gen #(.DW(DW)) u_nzp_gen (
    .data (rf.i_wdata),
    .nzp  (nzp_next)
  );

`ifdef LC4_RF_BYPASS_EN
  // Forward the in-flight writeback to either read port on index match
  always_comb begin
    rf.o_rs_data = regs[rf.i_rs];
    rf.o_rt_data = regs[rf.i_rt];
    if (rd_wr && (rf.i_rd == rf.i_rs))
      rf.o_rs_data = rf.i_wdata;
    if (rd_wr && (rf.i_rd == rf.i_rt))
      rf.o_rt_data = rf.i_wdata;
  end
`else
  // Plain array reads; a same-cycle write shows up after the edge
  always_comb begin
    rf.o_rs_data = regs[rf.i_rs];
    rf.o_rt_data = regs[rf.i_rt];
  end
`endif

  assign rf.o_nzp  = nzp_q;
  assign rf.o_priv = priv_q;

  // GPR writeback, cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++)
        regs[i] <= '0;
    end else if (rd_wr) begin
      regs[rf.i_rd] <= rf.i_wdata;
    end
  end

  // Condition code follows the written value, not the reg write enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      nzp_q <= NZP_RESET;
    else if (rf.gwe && rf.i_nzp_we)
      nzp_q <= nzp_next;
  end

  // TRAP enters OS mode and takes priority over RTI
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      priv_q <= PRIV_RESET;
    else if (rf.gwe && rf.i_is_trap)
      priv_q <= 1'b1;
    else if (rf.gwe && rf.i_is_rti)
      priv_q <= 1'b0;
  end

  logic unused_aw;
  assign unused_aw = ^AW;

endmodule

// File: tb/tb_lc4_regfile_wb.sv
// Directed bench for lc4_regfile_wb with an expected-value queue.
// Honours LC4_RF_BYPASS_EN for the same-cycle read expectations.
module tb_lc4_regfile_wb;
  import lc4_regfile_wb_pkg::*;

  localparam int SEL_RS   = 0;
  localparam int SEL_RT   = 1;
  localparam int SEL_NZP  = 2;
  localparam int SEL_PRIV = 3;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       tag;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t q[$];

  lc4_regfile_wb_if #(.AW(3), .DW(16)) rf_if ();

  lc4_regfile_wb #(.N_REGS(8), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "bench timeout");
  end

  task automatic push(input int sel, input logic [15:0] v,
                      input string tag);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        SEL_RS:   obs = rf_if.o_rs_data;
        SEL_RT:   obs = rf_if.o_rt_data;
        SEL_NZP:  obs = {13'd0, rf_if.o_nzp};
        default:  obs = {15'd0, rf_if.o_priv};
      endcase
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h",
               e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [2:0] idx,
                        input logic [15:0] v,
                        input string tag);
    rf_if.i_rs = idx;
    rf_if.i_rt = idx;
    #1;
    push(SEL_RS, v, {tag, "_rs"});
    push(SEL_RT, v, {tag, "_rt"});
    drain();
  endtask

  task automatic idle();
    rf_if.gwe       = 1'b0;
    rf_if.i_rd_we   = 1'b0;
    rf_if.i_nzp_we  = 1'b0;
    rf_if.i_is_trap = 1'b0;
    rf_if.i_is_rti  = 1'b0;
  endtask

  initial begin
    logic [15:0] nz_in [3];
    logic [15:0] nz_ex [3];
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    rf_if.i_rs    = '0;
    rf_if.i_rt    = '0;
    rf_if.i_rd    = '0;
    rf_if.i_wdata = '0;

    // power-on reset state
    #2;
    push(SEL_NZP, 16'h0000, "rst_nzp");
    push(SEL_PRIV, 16'h0001, "rst_priv");
    drain();
    for (int i = 0; i < 8; i++)
      rd_chk(3'(i), 16'h0000, "rst_reg");
    tick();
    tick();
    rst = 1'b0;

    // reg write, nzp and priv change in one cycle
    rf_if.gwe      = 1'b1;
    rf_if.i_rd     = 3'd2;
    rf_if.i_wdata  = 16'h5555;
    rf_if.i_rd_we  = 1'b1;
    rf_if.i_nzp_we = 1'b1;
    rf_if.i_is_rti = 1'b1;
    tick();
    idle();
    push(SEL_NZP, 16'h0001, "multi_nzp");
    push(SEL_PRIV, 16'h0000, "multi_priv");
    drain();
    rd_chk(3'd2, 16'h5555, "multi_r2");

    // asynchronous reset between edges
    @(negedge clk);
    rst = 1'b1;
    #1;
    push(SEL_NZP, 16'h0000, "arst_nzp");
    push(SEL_PRIV, 16'h0001, "arst_priv");
    drain();
    rd_chk(3'd2, 16'h0000, "arst_r2");
    rst = 1'b0;

    // write R3 then gated write attempt
    tick();
    rf_if.gwe     = 1'b1;
    rf_if.i_rd    = 3'd3;
    rf_if.i_wdata = 16'h1234;
    rf_if.i_rd_we = 1'b1;
    tick();
    idle();
    rd_chk(3'd3, 16'h1234, "wr_r3");
    rf_if.i_wdata = 16'hFFFF;
    rf_if.i_rd_we = 1'b1;
    tick();
    idle();
    rd_chk(3'd3, 16'h1234, "gwe0_r3");

    // NZP sequence with no register write
    nz_in[0] = 16'h8000; nz_ex[0] = 16'h0004;
    nz_in[1] = 16'h0000; nz_ex[1] = 16'h0002;
    nz_in[2] = 16'h0001; nz_ex[2] = 16'h0001;
    rf_if.i_rd = 3'd3;
    for (int i = 0; i < 3; i++) begin
      rf_if.gwe      = 1'b1;
      rf_if.i_nzp_we = 1'b1;
      rf_if.i_wdata  = nz_in[i];
      tick();
      idle();
      push(SEL_NZP, nz_ex[i], "nzp_seq");
      drain();
    end
    rd_chk(3'd3, 16'h1234, "nzp_noreg");
    rf_if.i_nzp_we = 1'b1;
    rf_if.i_wdata  = 16'h8000;
    tick();
    idle();
    push(SEL_NZP, 16'h0001, "nzp_gwe0");
    drain();

    // privilege transitions
    rf_if.gwe      = 1'b1;
    rf_if.i_is_rti = 1'b1;
    tick();
    idle();
    push(SEL_PRIV, 16'h0000, "rti");
    drain();
    rf_if.gwe       = 1'b1;
    rf_if.i_is_trap = 1'b1;
    rf_if.i_rd      = 3'd7;
    rf_if.i_wdata   = 16'h0201;
    rf_if.i_rd_we   = 1'b1;
    tick();
    idle();
    push(SEL_PRIV, 16'h0001, "trap");
    drain();
    rd_chk(3'd7, 16'h0201, "trap_r7");
    rf_if.gwe      = 1'b1;
    rf_if.i_is_rti = 1'b1;
    tick();
    idle();
    push(SEL_PRIV, 16'h0000, "rti2");
    drain();
    rf_if.gwe       = 1'b1;
    rf_if.i_is_trap = 1'b1;
    rf_if.i_is_rti  = 1'b1;
    tick();
    idle();
    push(SEL_PRIV, 16'h0001, "trap_wins");
    drain();
    rf_if.i_is_rti = 1'b1;
    tick();
    idle();
    push(SEL_PRIV, 16'h0001, "rti_gwe0");
    drain();

    // same-cycle read of a register being written
    rf_if.gwe     = 1'b1;
    rf_if.i_rd    = 3'd5;
    rf_if.i_wdata = 16'h1111;
    rf_if.i_rd_we = 1'b1;
    tick();
    rf_if.i_wdata = 16'hBEEF;
    rf_if.i_rs    = 3'd5;
    rf_if.i_rt    = 3'd3;
    #1;
`ifdef LC4_RF_BYPASS_EN
    push(SEL_RS, 16'hBEEF, "byp_rs");
`else
    push(SEL_RS, 16'h1111, "byp_rs");
`endif
    push(SEL_RT, 16'h1234, "byp_rt");
    drain();
    tick();
    idle();
    rd_chk(3'd5, 16'hBEEF, "byp_after");

    // reset raised with a write pending
    rf_if.gwe     = 1'b1;
    rf_if.i_rd    = 3'd1;
    rf_if.i_wdata = 16'h00AA;
    rf_if.i_rd_we = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    idle();
    @(negedge clk);
    rst = 1'b0;
    rd_chk(3'd1, 16'h0000, "rst_abort_r1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
